// File: rtl/uart_frame_loader.sv
// Turns the UART byte stream into framebuffer pixel writes: SOF-delimited frames with
// ESC byte-stuffing, and an idle timeout that drops back to hunting for the next SOF.
module uart_frame_loader #(
    parameter int         WIDTH   = 32,
    parameter int         HEIGHT  = 16,
    parameter logic [7:0] SOF     = 8'h7E,
    parameter logic [7:0] ESC     = 8'h7D,
    parameter int         TIMEOUT = 1_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [15:0] write_address,
    output logic [15:0] write_value,
    output logic        write_enable,
    output logic        frame_done,
    output logic        busy,
    output logic        error,
    output logic [15:0] frame_count
);
    localparam int          PIXELS = WIDTH * HEIGHT;
    localparam logic [15:0] LAST   = 16'(PIXELS - 1);
    localparam int          TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {HUNT, DATA, ESCD} state_t;

    state_t        state;
    logic          rx_ready_q;
    logic [15:0]   addr;
    logic [TW-1:0] timer;
    logic          new_byte;
    logic [7:0]    pix;

    assign new_byte = rx_ready & ~rx_ready_q;
    // The byte following an escape carries its value XORed with 0x20.
    assign pix      = (state == ESCD) ? (rx_data ^ 8'h20) : rx_data;
    assign busy     = (state == DATA) || (state == ESCD);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= HUNT;
            rx_ready_q    <= 1'b0;
            addr          <= '0;
            timer         <= '0;
            write_address <= '0;
            write_value   <= '0;
            write_enable  <= 1'b0;
            frame_done    <= 1'b0;
            error         <= 1'b0;
            frame_count   <= '0;
        end else begin
            rx_ready_q   <= rx_ready;
            write_enable <= 1'b0;
            frame_done   <= 1'b0;
            if (new_byte) begin
                // A byte arriving on the expiry cycle wins over the timeout.
                timer <= '0;
                if (state == HUNT) begin
                    if (rx_data == SOF) begin
                        state <= DATA;
                        addr  <= '0;
                    end
                end else if (rx_data == SOF) begin
                    state <= DATA;
                    addr  <= '0;
                    error <= 1'b1;
                end else if (rx_data == ESC) begin
                    if (state == DATA) begin
                        state <= ESCD;
                    end else begin
                        state <= HUNT;
                        addr  <= '0;
                        error <= 1'b1;
                    end
                end else begin
                    write_enable  <= 1'b1;
                    write_address <= addr;
                    write_value   <= {8'h00, pix};
                    if (addr == LAST) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        addr        <= '0;
                        state       <= HUNT;
                    end else begin
                        addr  <= addr + 16'd1;
                        state <= DATA;
                    end
                end
            end else if (state != HUNT) begin
                if (timer == TLAST) begin
                    state <= HUNT;
                    addr  <= '0;
                    timer <= '0;
                    error <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: a per-byte vector table plus hand-written
// long-frame, resync, timeout and reset sequences checked against a write log.
module tb_uart_frame_loader;
    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic [15:0] write_address, write_value, frame_count;
    logic        write_enable, frame_done, busy, error;

    uart_frame_loader #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_ready(rx_ready),
        .write_address(write_address), .write_value(write_value),
        .write_enable(write_enable), .frame_done(frame_done), .busy(busy),
        .error(error), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    typedef struct {int addr; int val; bit fd;} wr_t;
    wr_t log_q[$];

    always @(negedge clock) begin
        if (write_enable) log_q.push_back('{int'(write_address), int'(write_value), frame_done});
    end

    int passed = 0, total = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic do_reset();
        @(negedge clock) reset_n = 1'b0;
        @(negedge clock) reset_n = 1'b1;
    endtask

    // Raise rx_ready with a byte; return at the negedge right after the detecting edge.
    task automatic present(input logic [7:0] d);
        @(negedge clock);
        rx_data  = d;
        rx_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic release_rx();
        rx_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic send(input logic [7:0] d);
        present(d);
        release_rx();
    endtask

    // Sends a pixel value, stuffing it when it collides with SOF/ESC.
    task automatic send_pix(input logic [7:0] v);
        if (v == 8'h7E || v == 8'h7D) begin
            send(8'h7D);
            send(v ^ 8'h20);
        end else begin
            send(v);
        end
    endtask

    typedef struct {bit rst; logic [7:0] d; bit we; int addr; int val; bit busy; bit err;} vec_t;
    vec_t tbl[16];

    initial begin
        int bad, fds, fd_at;

        // rst, byte, write_enable, write_address, write_value, busy, error
        tbl[0]  = '{1, 8'h7E, 0, 0, 8'h00, 1, 0};
        tbl[1]  = '{0, 8'h7D, 0, 0, 8'h00, 1, 0};
        tbl[2]  = '{0, 8'h5E, 1, 0, 8'h7E, 1, 0};
        tbl[3]  = '{0, 8'h7D, 0, 0, 8'h7E, 1, 0};
        tbl[4]  = '{0, 8'h5D, 1, 1, 8'h7D, 1, 0};
        tbl[5]  = '{0, 8'h11, 1, 2, 8'h11, 1, 0};
        tbl[6]  = '{1, 8'h55, 0, 0, 8'h00, 0, 0};
        tbl[7]  = '{0, 8'hAA, 0, 0, 8'h00, 0, 0};
        tbl[8]  = '{0, 8'h7E, 0, 0, 8'h00, 1, 0};
        tbl[9]  = '{0, 8'h01, 1, 0, 8'h01, 1, 0};
        tbl[10] = '{0, 8'h7D, 0, 0, 8'h01, 1, 0};
        tbl[11] = '{0, 8'h7D, 0, 0, 8'h01, 0, 1};
        tbl[12] = '{0, 8'h7E, 0, 0, 8'h01, 1, 1};
        tbl[13] = '{0, 8'h7D, 0, 0, 8'h01, 1, 1};
        tbl[14] = '{0, 8'h7E, 0, 0, 8'h01, 1, 1};
        tbl[15] = '{0, 8'h33, 1, 0, 8'h33, 1, 1};

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_we", write_enable, 0);
        chk("rst_addr", write_address, 0);
        chk("rst_val", write_value, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", error, 0);
        chk("rst_fc", frame_count, 0);
        reset_n = 1'b1;

        // Byte-by-byte table: escapes, pre-SOF garbage, ESC ESC, ESC SOF
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            present(tbl[i].d);
            chk($sformatf("v%0d_we", i), write_enable, tbl[i].we);
            chk($sformatf("v%0d_addr", i), write_address, tbl[i].addr);
            chk($sformatf("v%0d_val", i), write_value, tbl[i].val);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("v%0d_err", i), error, tbl[i].err);
            release_rx();
        end

        // Full frame of 512 pixels, values 0x00..0xFF twice
        do_reset();
        log_q.delete();
        send(8'h7E);
        for (int i = 0; i < 512; i++) send_pix(8'(i));
        repeat (3) @(negedge clock);
        chk("t1_count", log_q.size(), 512);
        bad = 0; fds = 0; fd_at = -1;
        foreach (log_q[i]) begin
            if (log_q[i].addr != i || log_q[i].val != (i & 8'hFF)) bad++;
            if (log_q[i].fd) begin fds++; fd_at = i; end
        end
        chk("t1_seq_errors", bad, 0);
        chk("t1_fd_pulses", fds, 1);
        chk("t1_fd_index", fd_at, 511);
        chk("t1_fc", frame_count, 1);
        chk("t1_err", error, 0);
        chk("t1_busy", busy, 0);

        // Short frame restarted by a second SOF
        do_reset();
        log_q.delete();
        send(8'h7E);
        for (int i = 0; i < 10; i++) send(8'(i + 1));
        send(8'h7E);
        for (int i = 0; i < 512; i++) send(8'(i & 8'h3F));
        repeat (3) @(negedge clock);
        chk("t4_count", log_q.size(), 522);
        if (log_q.size() == 522) begin
            chk("t4_addr9", log_q[9].addr, 9);
            chk("t4_restart_addr", log_q[10].addr, 0);
            chk("t4_last_addr", log_q[521].addr, 511);
            chk("t4_last_fd", log_q[521].fd, 1);
        end
        chk("t4_err", error, 1);
        chk("t4_fc", frame_count, 1);

        // Byte landing exactly on the expiry cycle beats the timeout
        do_reset();
        log_q.delete();
        send(8'h7E);
        send(8'h21);
        repeat (TMO - 3) @(negedge clock);
        present(8'h22);
        chk("tmo_edge_we", write_enable, 1);
        chk("tmo_edge_addr", write_address, 1);
        chk("tmo_edge_err", error, 0);
        chk("tmo_edge_busy", busy, 1);
        release_rx();

        // Idle timeout aborts the frame, next byte ignored until SOF
        do_reset();
        log_q.delete();
        send(8'h7E);
        send(8'h01); send(8'h02); send(8'h03);
        repeat (TMO + 2) @(negedge clock);
        chk("t5_err", error, 1);
        chk("t5_busy", busy, 0);
        send(8'h42);
        repeat (2) @(negedge clock);
        chk("t5_ignored", log_q.size(), 3);
        send(8'h7E);
        send(8'h42);
        repeat (2) @(negedge clock);
        chk("t5_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("t5_addr", log_q[3].addr, 0);
            chk("t5_val", log_q[3].val, 8'h42);
        end

        // Reset mid-frame with rx_ready held high across it
        do_reset();
        send(8'h7E);
        for (int i = 0; i < 300; i++) send(8'(i & 8'h3F));
        chk("t6_pre_addr", write_address, 299);
        @(negedge clock);
        rx_data  = 8'h11;
        rx_ready = 1'b1;
        reset_n  = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        chk("t6_we", write_enable, 0);
        chk("t6_addr", write_address, 0);
        chk("t6_val", write_value, 0);
        chk("t6_busy", busy, 0);
        chk("t6_fc", frame_count, 0);
        log_q.delete();
        repeat (4) @(negedge clock);
        chk("t6_no_write", log_q.size(), 0);
        chk("t6_busy_after", busy, 0);
        chk("t6_err_after", error, 0);
        release_rx();
        release_rx();
        send(8'h7E);
        send(8'h05);
        repeat (2) @(negedge clock);
        chk("t6_recover_count", log_q.size(), 1);
        if (log_q.size() == 1) chk("t6_recover_addr", log_q[0].addr, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", passed, total);
        $fatal(1);
    end
endmodule
